// File: rtl/eth_phy_10g_tx_gearbox.sv
// rtl/eth_phy_10g_tx_gearbox.sv - 66:64 TX gearbox, 32 blocks packed into 33 SERDES words
module eth_phy_10g_tx_gearbox #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter bit CHECK_HDR  = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [HDR_WIDTH-1:0]  in_hdr_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [5:0]            out_seq_o,
  output logic                  out_sync_o,
  output logic                  bad_hdr_o
);

  localparam logic [5:0] LAST_SEQ = 6'd32;

  generate
    if (DATA_WIDTH != 64 || HDR_WIDTH != 2) begin : g_bad_param
      $error("eth_phy_10g_tx_gearbox supports only DATA_WIDTH=64 and HDR_WIDTH=2");
    end
  endgenerate

  logic [5:0]   seq_q, seq_d;
  logic [63:0]  res_q, res_d;
  logic [63:0]  out_data_q, out_data_d;
  logic [5:0]   out_seq_q, out_seq_d;
  logic         out_sync_q, out_sync_d;
  logic         bad_hdr_q, bad_hdr_d;

  logic [6:0]   shift;
  logic [65:0]  blk;
  logic [63:0]  res_mask;
  logic [127:0] cat;
  logic         hdr_bad;

  // Residual holds 2*seq valid bits; the new block lands directly above them.
  always_comb begin
    shift    = {seq_q, 1'b0};
    blk      = {in_data_i, in_hdr_i};
    res_mask = (64'd1 << shift) - 64'd1;
    cat      = {64'd0, res_q & res_mask} | ({62'd0, blk} << shift);
    hdr_bad  = CHECK_HDR && (in_hdr_i == 2'b00 || in_hdr_i == 2'b11);

    seq_d      = seq_q;
    res_d      = res_q;
    out_data_d = out_data_q;
    out_seq_d  = seq_q;
    out_sync_d = 1'b0;
    bad_hdr_d  = 1'b0;

    if (seq_q == LAST_SEQ) begin
      // Pause cycle: flush the full 64-bit residual, no block accepted.
      out_data_d = res_q;
      res_d      = 64'd0;
      seq_d      = 6'd0;
    end else begin
      out_data_d = cat[63:0];
      res_d      = cat[127:64];
      seq_d      = seq_q + 6'd1;
      out_sync_d = (seq_q == 6'd0);
      bad_hdr_d  = hdr_bad;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      seq_q      <= 6'd0;
      res_q      <= 64'd0;
      out_data_q <= 64'd0;
      out_seq_q  <= 6'd0;
      out_sync_q <= 1'b0;
      bad_hdr_q  <= 1'b0;
    end else begin
      seq_q      <= seq_d;
      res_q      <= res_d;
      out_data_q <= out_data_d;
      out_seq_q  <= out_seq_d;
      out_sync_q <= out_sync_d;
      bad_hdr_q  <= bad_hdr_d;
    end
  end

  assign in_ready_o = (seq_q != LAST_SEQ) && !rst_i;
  assign out_data_o = out_data_q;
  assign out_seq_o  = out_seq_q;
  assign out_sync_o = out_sync_q;
  assign bad_hdr_o  = CHECK_HDR ? bad_hdr_q : 1'b0;

endmodule

// File: tb/tb_eth_phy_10g_tx_gearbox.sv
// tb/tb_eth_phy_10g_tx_gearbox.sv - self-checking bench for the 66:64 TX gearbox
module tb_eth_phy_10g_tx_gearbox;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] in_data = 64'd0;
  logic [1:0]  in_hdr = 2'b01;
  logic        in_ready;
  logic [63:0] out_data;
  logic [5:0]  out_seq;
  logic        out_sync;
  logic        bad_hdr;

  always #5 clk = ~clk;

  eth_phy_10g_tx_gearbox #(.DATA_WIDTH(64), .HDR_WIDTH(2), .CHECK_HDR(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_hdr_i(in_hdr),
    .in_ready_o(in_ready), .out_data_o(out_data), .out_seq_o(out_seq),
    .out_sync_o(out_sync), .bad_hdr_o(bad_hdr)
  );

  typedef struct {
    logic [63:0] data;
    logic [5:0]  seq;
    logic        sync;
    logic        bad;
  } exp_t;

  typedef struct {
    logic [63:0] d;
    logic [1:0]  h;
    logic [63:0] x_data;
    logic [5:0]  x_seq;
    logic        x_sync;
    logic        x_bad;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   mseq  = 0;
  bit   bitq[$];
  bit   txq[$];
  bit   rxq[$];
  exp_t expq[$];

  logic [63:0] obs_data;
  logic [5:0]  obs_seq;
  logic        obs_sync, obs_bad, obs_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive, predict from the serial bit model, clock, compare.
  task automatic step(input logic r, input logic [63:0] d, input logic [1:0] h);
    exp_t        e;
    exp_t        g;
    logic [65:0] blk;
    logic        acc;
    rst = r; in_data = d; in_hdr = h;
    #1;
    obs_ready = in_ready;
    acc = !r && (mseq != 32);
    chk("in_ready", in_ready, acc);
    e.data = 64'd0; e.seq = 6'd0; e.sync = 1'b0; e.bad = 1'b0;
    if (r) begin
      bitq.delete();
      mseq = 0;
    end else begin
      if (acc) begin
        blk = {d, h};
        for (int i = 0; i < 66; i++) begin
          bitq.push_back(blk[i]);
          txq.push_back(blk[i]);
        end
      end
      for (int i = 0; i < 64; i++) e.data[i] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      e.seq  = mseq[5:0];
      e.sync = (mseq == 0);
      e.bad  = acc && (h == 2'b00 || h == 2'b11);
      mseq   = (mseq == 32) ? 0 : mseq + 1;
    end
    expq.push_back(e);
    @(posedge clk);
    #1;
    g = expq.pop_front();
    obs_data = out_data; obs_seq = out_seq; obs_sync = out_sync; obs_bad = bad_hdr;
    chk("out_data", out_data, g.data);
    chk("out_seq",  {58'd0, out_seq}, {58'd0, g.seq});
    chk("out_sync", out_sync, g.sync);
    chk("bad_hdr",  bad_hdr,  g.bad);
    if (!r) for (int i = 0; i < 64; i++) rxq.push_back(out_data[i]);
  endtask

  initial begin
    vec_t        vt[3];
    logic [63:0] d0, d1, d2, dk, dn;
    int          lows, low_idx, bad_cnt, bad_seq, diff;

    d0 = 64'h0123456789ABCDEF;
    d1 = 64'hFEDCBA9876543210;
    d2 = 64'h5555AAAA3333CCCC;
    vt[0] = '{d0, 2'b01, {d0[61:0], 2'b01}, 6'd0, 1'b1, 1'b0};
    vt[1] = '{d1, 2'b10, {d1[59:0], 2'b10, d0[63:62]}, 6'd1, 1'b0, 1'b0};
    vt[2] = '{d2, 2'b11, {d2[57:0], 2'b11, d1[63:60]}, 6'd2, 1'b0, 1'b1};

    // Reset state and first packed words.
    step(1'b1, 64'hDEAD, 2'b01);
    step(1'b1, 64'hBEEF, 2'b10);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, vt[i].d, vt[i].h);
      chk("tbl_data", obs_data, vt[i].x_data);
      chk("tbl_seq",  {58'd0, obs_seq}, {58'd0, vt[i].x_seq});
      chk("tbl_sync", obs_sync, vt[i].x_sync);
      chk("tbl_bad",  obs_bad,  vt[i].x_bad);
    end

    // Full sequence of D_k = k per byte, then pause and wrap.
    step(1'b1, 64'd0, 2'b01);
    lows = 0; low_idx = -1;
    for (int k = 0; k < 33; k++) begin
      dk = {8{k[7:0]}};
      step(1'b0, dk, 2'b01);
      if (!obs_ready) begin lows++; low_idx = k; end
    end
    chk("pause_count", lows, 1);
    chk("pause_index", low_idx, 32);
    chk("word33_data", obs_data, 64'h1F1F1F1F1F1F1F1F);
    chk("word33_seq",  {58'd0, obs_seq}, 64'd32);
    step(1'b0, 64'h0A0B0C0D0E0F1011, 2'b10);
    chk("wrap_seq",  {58'd0, obs_seq}, 64'd0);
    chk("wrap_sync", obs_sync, 1'b1);
    chk("wrap_data", obs_data, {64'h0A0B0C0D0E0F1011 & 64'h3FFFFFFFFFFFFFFF, 2'b10} & 64'hFFFFFFFFFFFFFFFF);

    // Three full sequences reassembled as a serial bitstream.
    step(1'b1, 64'd0, 2'b01);
    txq.delete(); rxq.delete();
    lows = 0;
    for (int k = 0; k < 99; k++) begin
      step(1'b0, {$urandom, $urandom}, ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10);
      if (!obs_ready) lows++;
    end
    chk("ready_low_3seq", lows, 3);
    chk("stream_len", rxq.size(), 96 * 66);
    diff = 0;
    for (int i = 0; i < txq.size() && i < rxq.size(); i++) if (txq[i] != rxq[i]) diff++;
    chk("stream_bits", diff, 0);

    // Invalid header on block 5.
    step(1'b1, 64'd0, 2'b01);
    bad_cnt = 0; bad_seq = -1;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, {$urandom, $urandom}, (k == 5) ? 2'b11 : 2'b01);
      if (obs_bad) begin bad_cnt++; bad_seq = obs_seq; end
    end
    chk("bad_count", bad_cnt, 1);
    chk("bad_seq", bad_seq, 5);

    // Reset in the middle of a sequence discards the residual.
    step(1'b1, 64'd0, 2'b01);
    for (int k = 0; k < 17; k++) step(1'b0, {$urandom, $urandom}, 2'b10);
    chk("mid_seq", {58'd0, obs_seq}, 64'd16);
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 2'b11);
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 2'b11);
    chk("rst_zero", {obs_data[62:0], obs_sync | obs_bad | (obs_seq != 0)}, 64'd0);
    dn = 64'hC3A5_0F1E_2D3C_4B5A;
    step(1'b0, dn, 2'b01);
    chk("post_rst_data", obs_data, {dn[61:0], 2'b01});
    chk("post_rst_seq",  {58'd0, obs_seq}, 64'd0);
    step(1'b0, d1, 2'b10);
    chk("post_rst_word1", obs_data, {d1[59:0], 2'b10, dn[63:62]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_phy_10g_tx_gearbox.md
Name: eth_phy_10g_tx_gearbox

Overview:
- 66:64 transmit gearbox between the 10G PHY TX scrambler/encoder output (64-bit data plus 2-bit sync header per cycle) and a 64-bit SERDES lane that has no internal gearbox.
- Packs 32 consecutive 66-bit blocks into 33 64-bit output words and repeats.
- Back-pressures upstream for one cycle in every 33 through in_ready.
- Sits directly downstream of the PHY TX path, on the tx_clk domain.

Parameters:
- DATA_WIDTH, 64, input and output data width; only 64 is supported, and any other value is an elaboration error.
- HDR_WIDTH, 2, sync header width; only 2 is supported.
- CHECK_HDR, 1, when 1 the block drives bad_hdr; when 0, bad_hdr is tied to 0.

Ports:
- clk  input  1  tx clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_WIDTH  scrambled block payload.
- in_hdr  input  HDR_WIDTH  sync header; 2'b01 = data, 2'b10 = control.
- in_ready  output  1  block accepted on a rising edge when high.
- out_data  output  DATA_WIDTH  word to SERDES; bit 0 is transmitted first.
- out_seq  output  6  sequence index (0..32) of the word currently on out_data.
- out_sync  output  1  high while out_data carries sequence word 0.
- bad_hdr  output  1  one-cycle pulse, aligned with the output word containing the header of an accepted block whose header is 2'b00 or 2'b11.

Behaviour:
- State:
  - seq: 6-bit, 0..32.
  - res: 64-bit residual register; the valid bit count is 2*seq.
- in_ready = (seq != 32) && !rst. This is combinational from registered seq. Inputs are ignored while rst is high.
- Block bit order: blk[65:0] = {in_data, in_hdr}. The header occupies the lowest two bits and is transmitted first.
- Cycle with seq < 32 (in_ready = 1, block always accepted; upstream must present a new block every ready cycle):
  - cat[127:0] = res[2*seq-1:0] | (blk << 2*seq).
  - out_data <= cat[63:0].
  - res <= cat[127:64].
  - seq <= seq + 1.
- Cycle with seq == 32 (in_ready = 0):
  - out_data <= res.
  - res <= 0.
  - seq <= 0.
  - in_data and in_hdr are ignored.
- Registered outputs:
  - out_seq and out_sync follow the seq value used to produce the registered word.
  - Latency: a block accepted on edge N appears, starting at its header, in out_data after edge N; one cycle of latency.
- Residual bits above 2*seq are don't-care internally, but must be masked so that cat is exact.
- Wrap-around: after 32 accepts plus 1 pause, the pattern restarts at seq 0 with no gap in out_data.
- Reset (any cycle, including mid-sequence):
  - seq <= 0, res <= 0, out_data <= 0, out_seq <= 0, out_sync <= 0, bad_hdr <= 0.
  - in_ready reads 0 while rst is high and 1 on the first cycle after release.
  - A partially packed sequence is discarded.
- bad_hdr:
  - Registered; asserted for the output cycle of the accepted block with an invalid header.
  - The data still passes through unmodified.
  - Never asserted on a pause cycle.
- No gaps and no stall input: out_data is valid every cycle after reset release, starting with sequence word 0.

Test Plan:
- Reset release, then block0 = {D0, 2'b01} with D0 = 64'h0123456789ABCDEF:
  - First out_data = {D0[61:0], 2'b01}.
  - out_seq = 0, out_sync = 1.
- Next block1 = {D1, 2'b10} with D1 = 64'hFEDCBA9876543210:
  - out_data = {D1[59:0], 2'b10, D0[63:62]}.
  - out_seq = 1, out_sync = 0.
- Feed 32 blocks with D_k = k replicated per byte (e.g. 64'h1F1F1F1F1F1F1F1F for k = 31):
  - in_ready falls to 0 exactly on the 33rd cycle.
  - The 33rd word equals D31 = 64'h1F1F1F1F1F1F1F1F.
  - out_seq = 32.
  - The next word restarts with seq 0.
- Run 3 full sequences (99 cycles), reassembling out_data as a serial bitstream:
  - Bitstream equals the concatenation of {data, hdr} for all 96 blocks.
  - in_ready low count = 3.
- Block 5 sent with hdr 2'b11:
  - bad_hdr pulses high exactly once, on the cycle out_seq = 5.
  - The word content still matches the packing formula.
- Assert rst at seq = 17 for 2 cycles:
  - All outputs are 0 during reset.
  - After release, out_seq restarts at 0.
  - The first word after release is {next D[61:0], hdr}.
  - No residual bits from before the reset appear.
